// File: rtl/controle_pwm_motores_if.sv
// Write/stop bus between the operator logic and the motor PWM controller.
// The master drives select, speed, write strobe and emergency stop.
interface controle_pwm_motores_if #(
   parameter int LARGURA_S = 2,
   parameter int LARGURA_V = 4
);
   logic [LARGURA_S-1:0] S;
   logic [LARGURA_V-1:0] V;
   logic                 Escreve;
   logic                 Parar;

   modport master (
      output S,
      output V,
      output Escreve,
      output Parar
   );

   modport slave (
      input S,
      input V,
      input Escreve,
      input Parar
   );
endinterface

// File: rtl/controle_pwm_motores.sv
// Per-motor target/duty registers with soft-start ramp, shared-period PWM
// generation and an all-motor emergency stop.
module controle_pwm_motores #(
   parameter int N_MOTORES = 4,
   parameter int LARGURA_S = 2,
   parameter int LARGURA_V = 4,
   parameter int DIV_RAMPA = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   controle_pwm_motores_if.slave          bus,
   output logic [N_MOTORES-1:0]           Pwm,
   output logic [N_MOTORES*LARGURA_V-1:0] Velocidade_atual,
   output logic [N_MOTORES-1:0]           Em_rampa
);

   localparam int LARGURA_P = (DIV_RAMPA > 1) ? $clog2(DIV_RAMPA) : 1;
   localparam logic [LARGURA_V-1:0] CNT_MAX = LARGURA_V'((2**LARGURA_V) - 2);
   localparam logic [LARGURA_V-1:0] UM_V    = LARGURA_V'(1);
   localparam logic [LARGURA_P-1:0] PRE_MAX = LARGURA_P'(DIV_RAMPA - 1);
   localparam logic [LARGURA_P-1:0] UM_P    = LARGURA_P'(1);

   logic [LARGURA_V-1:0] r_cnt;
   logic [LARGURA_P-1:0] r_pre;
   logic [LARGURA_V-1:0] r_alvo [N_MOTORES];
   logic [LARGURA_V-1:0] r_duty [N_MOTORES];
   logic [N_MOTORES-1:0] r_pwm;
   logic                 w_tick;

   assign w_tick = (r_pre == PRE_MAX);

   // The period counter keeps running through an emergency stop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_pre <= '0;
         r_pwm <= '0;
         for (int i = 0; i < N_MOTORES; i++) begin
            r_alvo[i] <= '0;
            r_duty[i] <= '0;
         end
      end else begin
         r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + UM_V;
         if (bus.Parar) begin
            r_pre <= '0;
            r_pwm <= '0;
            for (int i = 0; i < N_MOTORES; i++) begin
               r_alvo[i] <= '0;
               r_duty[i] <= '0;
            end
         end else begin
            r_pre <= w_tick ? '0 : r_pre + UM_P;
            for (int i = 0; i < N_MOTORES; i++) begin
               r_pwm[i] <= (r_cnt < r_duty[i]);
               if (w_tick) begin
                  if (r_duty[i] < r_alvo[i])
                     r_duty[i] <= r_duty[i] + UM_V;
                  else if (r_duty[i] > r_alvo[i])
                     r_duty[i] <= r_duty[i] - UM_V;
               end
               if (bus.Escreve && (bus.S == LARGURA_S'(i)))
                  r_alvo[i] <= bus.V;
            end
         end
      end
   end

   assign Pwm = r_pwm;

   for (genvar g = 0; g < N_MOTORES; g++) begin : g_saida
      assign Velocidade_atual[g*LARGURA_V +: LARGURA_V] = r_duty[g];
      assign Em_rampa[g] = (r_duty[g] != r_alvo[g]);
   end

endmodule
